// File: rtl/vx_tcu_drl_align_pipe_pkg.sv
// Shared definitions for the TCU DRL alignment pipeline: alignment geometry helpers
// and the request tag carried alongside every beat.
package vx_tcu_drl_align_pipe_pkg;

    localparam int TCU_REQ_ID_W = 32;

    // Width of the pre-shifted magnitude; also the shift count at which everything is lost.
    function automatic int shift_mag_w(input int w);
        return 2 * w - 24;
    endfunction

    function automatic int prod_pre_shift(input int w);
        return w - 23;
    endfunction

    function automatic int c_pre_shift(input int w);
        return w - 24;
    endfunction

    typedef struct packed {
        logic [TCU_REQ_ID_W-1:0] req_id;
        logic                    is_int;
    } tcu_tag_t;

endpackage

// File: rtl/vx_tcu_drl_align_lane.sv
// One lane of the alignment stage: pre-shift, right shift with sticky collection,
// and conversion from sign-magnitude to 2's complement. Purely combinational.
module vx_tcu_drl_align_lane
    import vx_tcu_drl_align_pipe_pkg::*;
#(
    parameter int W    = 25,
    parameter int WA   = W + 2,
    parameter int EXPW = 8,
    parameter bit IS_C = 1'b0
) (
    input  logic [W-1:0]         sig_in,
    input  logic [EXPW-1:0]      shift,
    input  logic                 masked,
    input  logic                 is_int,
    output logic signed [WA-1:0] sig_out,
    output logic                 sticky
);

    localparam int S   = shift_mag_w(W);
    localparam int PRE = IS_C ? c_pre_shift(W) : prod_pre_shift(W);

    logic [S-1:0]         ext;
    logic [S-1:0]         lost_mask;
    logic [WA-2:0]        adj;
    logic signed [WA-1:0] mag_ext;
    logic signed [W-1:0]  sig_int;
    logic                 overshift;

    always_comb begin
        ext       = S'(sig_in[W-2:0]) << PRE;
        overshift = (32'(shift) >= S);
        lost_mask = ~({S{1'b1}} << shift);
        adj       = overshift ? '0 : (WA-1)'(ext >> shift);
        mag_ext   = signed'({1'b0, adj});
        sig_int   = signed'(sig_in);
        sig_out   = '0;
        sticky    = 1'b0;
        if (is_int) begin
            sig_out = WA'(sig_int);
        end else if (!masked) begin
            sig_out = sig_in[W-1] ? -mag_ext : mag_ext;
            sticky  = overshift ? |ext : |(ext & lost_mask);
        end
    end

endmodule

// File: rtl/vx_tcu_drl_align_pipe.sv
// Elastic FEDP alignment stage: max-exponent search, per-lane alignment and sticky,
// with valid/ready backpressure and a 1- or 2-deep register pipeline.
module vx_tcu_drl_align_pipe
    import vx_tcu_drl_align_pipe_pkg::*;
#(
    parameter string INSTANCE_ID = "",
    parameter int    N           = 5,
    parameter int    W           = 25,
    parameter int    WA          = W + 2,
    parameter int    EXPW        = 8,
    parameter int    LATENCY     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    output logic                ready_in,
    input  logic [31:0]         req_id,
    input  logic                is_int,
    input  logic [N-1:0]        lane_zero,
    input  logic [N*EXPW-1:0]   exps_in,
    input  logic [N*W-1:0]      sigs_in,
    output logic                valid_out,
    input  logic                ready_out,
    output logic [31:0]         req_id_out,
    output logic [EXPW-1:0]     max_exp,
    output logic [N*WA-1:0]     sigs_out,
    output logic [N-1:0]        sticky_bits,
    output logic                is_int_out
);

    typedef struct packed {
        tcu_tag_t               tag;
        logic [EXPW-1:0]        max_exp;
        logic [N-1:0]           mask;
        logic [N-1:0][EXPW-1:0] shift;
        logic [N-1:0][W-1:0]    sigs;
    } stage_a_t;

    logic                 en;
    stage_a_t             a_cmb;
    stage_a_t             b_pay;
    logic                 b_vld;
    logic [EXPW-1:0]      max_c;
    logic [N-1:0][WA-1:0] lane_sig;
    logic [N-1:0]         lane_sticky;

    // Whole pipe stalls together, so bubbles are preserved rather than squeezed out.
    assign en       = ~valid_out | ready_out;
    assign ready_in = en;

    // Stage A: max exponent over unmasked lanes and per-lane shift distance
    always_comb begin
        max_c = '0;
        for (int i = 0; i < N; i++) begin
            if (!lane_zero[i] && exps_in[i*EXPW +: EXPW] > max_c)
                max_c = exps_in[i*EXPW +: EXPW];
        end
        if (is_int)
            max_c = '0;
        a_cmb.tag.req_id = req_id;
        a_cmb.tag.is_int = is_int;
        a_cmb.max_exp    = max_c;
        a_cmb.mask       = lane_zero;
        a_cmb.sigs       = sigs_in;
        for (int i = 0; i < N; i++)
            a_cmb.shift[i] = max_c - exps_in[i*EXPW +: EXPW];
    end

    generate
        if (LATENCY == 2) begin : g_stage_a_reg
            stage_a_t pay_p0;
            logic     vld_p0;

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    vld_p0 <= 1'b0;
                else if (en)
                    vld_p0 <= valid_in;
            end

            always_ff @(posedge clk) begin
                if (en && valid_in)
                    pay_p0 <= a_cmb;
            end

            assign b_pay = pay_p0;
            assign b_vld = vld_p0;
        end else if (LATENCY == 1) begin : g_stage_a_comb
            assign b_pay = a_cmb;
            assign b_vld = valid_in;
        end else begin : g_bad_latency
            $error("vx_tcu_drl_align_pipe %s: LATENCY must be 1 or 2", INSTANCE_ID);
        end
    endgenerate

    // Stage B: per-lane alignment
    for (genvar g = 0; g < N; g++) begin : g_lane
        vx_tcu_drl_align_lane #(
            .W    (W),
            .WA   (WA),
            .EXPW (EXPW),
            .IS_C (g == N - 1)
        ) u_lane (
            .sig_in  (b_pay.sigs[g]),
            .shift   (b_pay.shift[g]),
            .masked  (b_pay.mask[g]),
            .is_int  (b_pay.tag.is_int),
            .sig_out (lane_sig[g]),
            .sticky  (lane_sticky[g])
        );
    end

    // Output register: data only moves with a valid beat so idle outputs keep the last result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out   <= 1'b0;
            req_id_out  <= '0;
            is_int_out  <= 1'b0;
            max_exp     <= '0;
            sigs_out    <= '0;
            sticky_bits <= '0;
        end else if (en) begin
            valid_out <= b_vld;
            if (b_vld) begin
                req_id_out  <= b_pay.tag.req_id;
                is_int_out  <= b_pay.tag.is_int;
                max_exp     <= b_pay.max_exp;
                sigs_out    <= lane_sig;
                sticky_bits <= lane_sticky;
            end
        end
    end

`ifdef DBG_TRACE_TCU
    always_ff @(posedge clk) begin
        if (valid_out && ready_out)
            $display("%t %s: req_id=0x%0h is_int=%0d max_exp=%0d sticky=%b sigs=0x%0h",
                     $time, INSTANCE_ID, req_id_out, is_int_out, max_exp, sticky_bits, sigs_out);
    end
`endif

endmodule

// File: doc/vx_tcu_drl_align_pipe.md
Name: vx_tcu_drl_align_pipe

Overview:
- Pipelined, elastic successor to the FEDP alignment stage of the TCU dot-product (DRL) datapath.
- Finds the maximum exponent across N lanes and derives each lane's right-shift amount internally; no precomputed shift input.
- Aligns sign-magnitude significands to 2's complement, produces per-lane sticky bits, and carries req_id plus the max exponent to the adder tree.
- Adds valid/ready backpressure, per-lane zero masking, an integer bypass mode and a configurable 1- or 2-stage pipeline.

Parameters:
- INSTANCE_ID, "", trace tag.
- N, 5, lane count; lanes 0..N-2 are product terms, lane N-1 is the accumulator (C) term.
- W, 25, input significand width: sign at bit W-1, magnitude W-2:0; W >= 24.
- WA, W+2, output significand width.
- EXPW, 8, unsigned biased exponent width.
- LATENCY, 2, pipeline depth (1 or 2); any other value is an elaboration error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  input beat valid
- ready_in  out  1  block accepts a beat
- req_id  in  32  request tag
- is_int  in  1  integer mode
- lane_zero  in  N  lane is exact zero
- exps_in  in  N*EXPW  per-lane exponents
- sigs_in  in  N*W  per-lane sign-magnitude significands
- valid_out  out  1  output beat valid
- ready_out  in  1  downstream accepts
- req_id_out  out  32  tag passed through
- max_exp  out  EXPW  max exponent over unmasked lanes
- sigs_out  out  N*WA  aligned 2's-complement significands
- sticky_bits  out  N  per-lane sticky
- is_int_out  out  1  mode passed through

Behaviour:
- Reset (asynchronous, active-high): every stage-valid register = 0; valid_out = 0; all data outputs = 0. Reset mid-flight discards in-flight beats. First accept is possible the cycle after deassertion.
- Handshake: global enable en = ~valid_out | ready_out; ready_in = en.
  - A beat is accepted when valid_in & ready_in.
  - All stages advance only when en = 1; bubbles do not collapse.
  - Outputs are stable while valid_out & ~ready_out.
  - Throughput is 1 beat/cycle with ready_out held high.
  - Latency: accept to valid_out = LATENCY cycles.
- Stage A (max/shift):
  - max_exp = max of exps_in[i] over lanes with lane_zero[i] = 0; 0 if all lanes are masked.
  - shift[i] = max_exp - exps_in[i], EXPW bits, never negative for unmasked lanes.
  - With LATENCY = 2, shift[], sigs, mask, is_int and req_id are registered here.
- Stage B (align), with S = 2W-24 (SHIFT_MAG_W):
  - Product lanes: ext = {mag, (W-23) zeros}.
  - C lane: ext = {1 zero, mag, (W-24) zeros}.
  - If shift >= S (overshift): adj = 0 and sticky = |ext.
  - Otherwise: adj = (ext >> shift)[WA-2:0], and sticky = OR of the bits shifted out.
  - sigs_out[i] = sign ? -{0,adj} : {0,adj}, computed in WA bits.
- Masked lanes: sigs_out = 0, sticky = 0.
- is_int = 1:
  - sigs_out[i] = sigs_in[i] sign-extended from W to WA bits.
  - sticky = 0; max_exp = 0; exponents and lane_zero are ignored.
- The final register stage drives all outputs.
- Under DBG_TRACE_TCU, trace each accepted output beat (valid_out & ready_out).

Decomposition:
- The shared tcu package holds:
  - function for the shift magnitude width, S = 2W-24;
  - constants for the product and C-term pre-shift amounts (W-23 and W-24);
  - a packed stage-A payload struct (req_id, is_int, mask, shift[], sigs).
- One sub-module, vx_tcu_drl_align_lane: purely combinational pre-shift, shift, sticky and 2's complement for one lane, with the C-term selected by parameter. It is instantiated N times.
- The top module owns the max tree, the elastic pipeline registers and the handshake.

Test Plan (W = 25, S = 26, WA = 27):
- Basic align:
  - Stimulus: exps {10,8,7,10,10}, mags 0x000003, signs 0, ready_out = 1.
  - Response after 2 cycles: sigs_out {0xC, 0x3, 0x1, 0xC, 0x6}, sticky {0,0,1,0,0}, max_exp = 10.
- Sign and overshift:
  - Lane 0: sign 1, mag 0x000001, exp 40 → sigs_out 0x7FFFFFC.
  - Lane 1: exp 10, mag 0x1 (shift 30) → sigs_out 0, sticky 1.
- Masking:
  - Lane 0 exp 200 with lane_zero[0] = 1; remaining lanes exp 5 → max_exp = 5, lane 0 output 0.
  - All lanes masked → max_exp = 0.
- Integer mode: is_int = 1, sigs_in lane 0 = 0x1FFFFFF → sigs_out 0x7FFFFFF, sticky 0, max_exp 0.
- Backpressure:
  - Stream req_id 1..6 back-to-back; hold ready_out = 0 for cycles 3-5.
  - ready_in drops and outputs hold stable; all 6 ids exit in order with no loss or duplication.
- Reset mid-flight:
  - Assert reset with 2 beats in flight → valid_out = 0 immediately (asynchronous) and outputs 0.
  - After deassertion, a new beat emerges after exactly LATENCY cycles (also run with LATENCY = 1).
